climate_zone_ctrl: RTL and testbench

//  Multi-zone cold-storage actuator controller, parametrised in zone count and data width.

---
 rtl/climate_zone_ctrl.sv | 178 +++++++++++++++++
 tb/tb_climate_zone_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/climate_zone_ctrl.sv
// Multi-zone cold-storage actuator controller: per-zone fan/humidifier
// with hysteresis, minimum dwell, auto/manual mode and sensor-timeout fail-safe.
module climate_zone_ctrl #(
    parameter int NUM_ZONES     = 2,
    parameter int DATA_W        = 8,
    parameter int TICK_DIV      = 100_000_000,
    parameter int MIN_DWELL     = 30,
    parameter int TIMEOUT_TICKS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic [NUM_ZONES*DATA_W-1:0]   temperature,
    input  logic [NUM_ZONES*DATA_W-1:0]   humidity,
    input  logic [DATA_W-1:0]             temp_set,
    input  logic [DATA_W-1:0]             temp_hyst,
    input  logic [DATA_W-1:0]             hum_set,
    input  logic [DATA_W-1:0]             hum_hyst,
    input  logic                          mode_auto,
    input  logic [NUM_ZONES-1:0]          man_fan,
    input  logic [NUM_ZONES-1:0]          man_hum,
    output logic [NUM_ZONES-1:0]          fan_on,
    output logic [NUM_ZONES-1:0]          hum_on,
    output logic                          sensor_fault,
    output logic                          tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int XW = DATA_W + 1;
    localparam int NA = 2 * NUM_ZONES;

    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DW_MAX  = DW'(MIN_DWELL);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_TICKS);

    // Bit 1 of the encoding is the actuator drive itself.
    typedef enum logic [1:0] {
        OFF_HOLD  = 2'b00,
        OFF_READY = 2'b01,
        ON_HOLD   = 2'b10,
        ON_READY  = 2'b11
    } act_t;

    logic [PW-1:0]               pre;
    logic [TW-1:0]               to_cnt;
    logic [NUM_ZONES*DATA_W-1:0] t_q;
    logic [NUM_ZONES*DATA_W-1:0] h_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pre == PRE_MAX);
            pre  <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q <= '0;
            h_q <= '0;
        end else if (sample_valid) begin
            t_q <= temperature;
            h_q <= humidity;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt       <= '0;
            sensor_fault <= 1'b0;
        end else if (sample_valid) begin
            to_cnt       <= '0;
            sensor_fault <= 1'b0;
        end else if (tick && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_MAX - 1'b1)
                sensor_fault <= 1'b1;
        end
    end

    logic [NUM_ZONES-1:0] fan_req_on, fan_req_off;
    logic [NUM_ZONES-1:0] hum_req_on, hum_req_off;

    // Comparisons are widened by one bit so setpoint+band never wraps.
    always_comb begin
        fan_req_on  = '0;
        fan_req_off = '0;
        hum_req_on  = '0;
        hum_req_off = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            if (sensor_fault) begin
                fan_req_on[z]  = 1'b1;
                hum_req_off[z] = 1'b1;
            end else begin
                fan_req_on[z]  = XW'(t_q[z*DATA_W +: DATA_W]) >
                                 (XW'(temp_set) + XW'(temp_hyst));
                fan_req_off[z] = t_q[z*DATA_W +: DATA_W] <= temp_set;
                hum_req_on[z]  = (XW'(h_q[z*DATA_W +: DATA_W]) + XW'(hum_hyst)) <
                                 XW'(hum_set);
                hum_req_off[z] = h_q[z*DATA_W +: DATA_W] >= hum_set;
            end
        end
    end

    logic [NA-1:0] req_on, req_off, man;
    assign req_on  = {hum_req_on, fan_req_on};
    assign req_off = {hum_req_off, fan_req_off};
    assign man     = {man_hum, man_fan};

    act_t          st    [NA];
    act_t          st_nx [NA];
    logic [DW-1:0] cnt   [NA];
    logic [DW-1:0] cnt_nx[NA];

    always_comb begin
        for (int a = 0; a < NA; a++) begin
            st_nx[a]  = st[a];
            cnt_nx[a] = cnt[a];
            unique case (st[a])
                OFF_HOLD: if (tick) begin
                    if (cnt[a] == DW_MAX - 1'b1) begin
                        st_nx[a]  = OFF_READY;
                        cnt_nx[a] = DW_MAX;
                    end else begin
                        cnt_nx[a] = cnt[a] + 1'b1;
                    end
                end
                ON_HOLD: if (tick) begin
                    if (cnt[a] == DW_MAX - 1'b1) begin
                        st_nx[a]  = ON_READY;
                        cnt_nx[a] = DW_MAX;
                    end else begin
                        cnt_nx[a] = cnt[a] + 1'b1;
                    end
                end
                OFF_READY: if (mode_auto && req_on[a]) begin
                    st_nx[a]  = ON_HOLD;
                    cnt_nx[a] = '0;
                end
                ON_READY: if (mode_auto && req_off[a]) begin
                    st_nx[a]  = OFF_HOLD;
                    cnt_nx[a] = '0;
                end
            endcase
            // Manual commands bypass dwell but still restart it.
            if (!mode_auto && (man[a] != st[a][1])) begin
                st_nx[a]  = man[a] ? ON_HOLD : OFF_HOLD;
                cnt_nx[a] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < NA; a++) begin
            if (!rst_n) begin
                st[a]  <= OFF_HOLD;
                cnt[a] <= '0;
            end else begin
                st[a]  <= st_nx[a];
                cnt[a] <= cnt_nx[a];
            end
        end
    end

    always_comb begin
        fan_on = '0;
        hum_on = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            fan_on[z] = st[z][1];
            hum_on[z] = st[NUM_ZONES+z][1];
        end
    end

endmodule

// File: tb/tb_climate_zone_ctrl.sv
// Directed bench for climate_zone_ctrl: vector table plus
// hand-timed dwell, timeout, manual-mode and reset sequences.
module tb_climate_zone_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] temperature;
    logic [15:0] humidity;
    logic [7:0]  temp_set, temp_hyst, hum_set, hum_hyst;
    logic        mode_auto;
    logic [1:0]  man_fan, man_hum;
    logic [1:0]  fan_on, hum_on;
    logic        sensor_fault;
    logic        tick;

    int checks = 0;
    int errors = 0;

    climate_zone_ctrl #(
        .NUM_ZONES(2), .DATA_W(8), .TICK_DIV(4),
        .MIN_DWELL(3), .TIMEOUT_TICKS(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .temperature(temperature), .humidity(humidity),
        .temp_set(temp_set), .temp_hyst(temp_hyst),
        .hum_set(hum_set), .hum_hyst(hum_hyst),
        .mode_auto(mode_auto), .man_fan(man_fan), .man_hum(man_hum),
        .fan_on(fan_on), .hum_on(hum_on),
        .sensor_fault(sensor_fault), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] t0, t1, h0, h1;
        logic [1:0] fan, hum;
    } vec_t;

    vec_t vecs[6];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            do begin
                cyc();
                k++;
            end while (tick !== 1'b1 && k < 20);
            if (tick !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL tick_wait: got no tick expected tick within 20");
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic sample(input logic [7:0] t0, input logic [7:0] t1,
                          input logic [7:0] h0, input logic [7:0] h1);
        temperature  = {t1, t0};
        humidity     = {h1, h0};
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic defaults();
        temp_set  = 8'd4;
        temp_hyst = 8'd2;
        hum_set   = 8'd60;
        hum_hyst  = 8'd5;
    endtask

    initial begin
        int k;
        vecs[0] = '{8'd8,   8'd4, 8'd54, 8'd60, 2'b01, 2'b01};
        vecs[1] = '{8'd5,   8'd5, 8'd58, 8'd58, 2'b01, 2'b01};
        vecs[2] = '{8'd4,   8'd7, 8'd60, 8'd54, 2'b10, 2'b10};
        vecs[3] = '{8'd6,   8'd6, 8'd55, 8'd59, 2'b10, 2'b10};
        vecs[4] = '{8'd0,   8'd0, 8'd61, 8'd61, 2'b00, 2'b00};
        vecs[5] = '{8'd255, 8'd7, 8'd0,  8'd0,  2'b11, 2'b11};

        rst_n = 1'b0;
        sample_valid = 1'b0;
        temperature = '0;
        humidity = {8'd60, 8'd60};
        mode_auto = 1'b1;
        man_fan = '0;
        man_hum = '0;
        defaults();

        do_reset();
        chk("rst_fan", 32'(fan_on), 0);
        chk("rst_hum", 32'(hum_on), 0);
        chk("rst_fault", 32'(sensor_fault), 0);
        chk("rst_tick", 32'(tick), 0);
        k = 0;
        do begin cyc(); k++; end while (tick !== 1'b1 && k < 20);
        chk("first_tick", k, 4);
        k = 0;
        do begin cyc(); k++; end while (tick !== 1'b1 && k < 20);
        chk("tick_period", k, 4);

        // Reset dwell then fan on; early cool-down held until dwell ends.
        do_reset();
        sample(8'd8, 8'd4, 8'd60, 8'd60);
        wait_ticks(2);
        cyc();
        chk("t1_dwell2", 32'(fan_on), 0);
        wait_ticks(1);
        cyc();
        chk("t1_ready", 32'(fan_on), 0);
        cyc();
        chk("t1_on", 32'(fan_on), 32'b01);
        wait_ticks(1);
        sample(8'd0, 8'd4, 8'd60, 8'd60);
        wait_ticks(1);
        cyc();
        chk("t3_hold", 32'(fan_on), 32'b01);
        wait_ticks(1);
        cyc();
        chk("t3_ready", 32'(fan_on), 32'b01);
        cyc();
        chk("t3_off", 32'(fan_on), 0);

        do_reset();
        foreach (vecs[i]) begin
            sample(vecs[i].t0, vecs[i].t1, vecs[i].h0, vecs[i].h1);
            wait_ticks(5);
            cyc();
            chk($sformatf("vec%0d_fan", i), 32'(fan_on), 32'(vecs[i].fan));
            chk($sformatf("vec%0d_hum", i), 32'(hum_on), 32'(vecs[i].hum));
        end

        temp_set  = 8'd250;
        temp_hyst = 8'd10;
        hum_set   = 8'd3;
        hum_hyst  = 8'd5;
        sample(8'd0, 8'd0, 8'd3, 8'd3);
        wait_ticks(5);
        cyc();
        chk("wrap_pre_fan", 32'(fan_on), 0);
        chk("wrap_pre_hum", 32'(hum_on), 0);
        sample(8'd255, 8'd255, 8'd0, 8'd0);
        wait_ticks(5);
        cyc();
        chk("wrap_fan", 32'(fan_on), 0);
        chk("wrap_hum", 32'(hum_on), 0);
        defaults();

        // Timeout: captured H=0 turns humidifiers on, fault reverses it.
        do_reset();
        wait_ticks(9);
        cyc();
        chk("to_9", 32'(sensor_fault), 0);
        chk("to_hum_pre", 32'(hum_on), 32'b11);
        wait_ticks(1);
        cyc();
        chk("to_10", 32'(sensor_fault), 1);
        wait_ticks(1);
        cyc();
        chk("fault_fan", 32'(fan_on), 32'b11);
        chk("fault_hum", 32'(hum_on), 0);
        sample(8'd0, 8'd0, 8'd60, 8'd60);
        chk("fault_clr", 32'(sensor_fault), 0);

        do_reset();
        sample(8'd0, 8'd0, 8'd60, 8'd60);
        mode_auto = 1'b0;
        man_fan   = 2'b01;
        man_hum   = 2'b00;
        cyc();
        chk("man_fan", 32'(fan_on), 32'b01);
        chk("man_hum", 32'(hum_on), 0);
        mode_auto = 1'b1;
        cyc();
        chk("auto_resume", 32'(fan_on), 32'b01);
        wait_ticks(2);
        cyc();
        chk("auto_dwell", 32'(fan_on), 32'b01);
        wait_ticks(1);
        cyc();
        cyc();
        chk("auto_off", 32'(fan_on), 0);
        mode_auto = 1'b0;
        man_fan   = 2'b11;
        man_hum   = 2'b11;
        cyc();
        chk("man_all_fan", 32'(fan_on), 32'b11);
        chk("man_all_hum", 32'(hum_on), 32'b11);
        mode_auto = 1'b1;
        wait_ticks(1);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_fan", 32'(fan_on), 0);
        chk("mid_rst_hum", 32'(hum_on), 0);
        chk("mid_rst_tick", 32'(tick), 0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
